// File: rtl/wb_arbiter2.sv
// Two-master, one-slave classic Wishbone arbiter with round-robin grant held for a whole CYC
// and a bus watchdog that answers a hung slave with a one-cycle ERR to the owner.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [31:0] s_addr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i
);

    typedef enum logic [1:0] {IDLE, BUS0, BUS1} state_e;

    localparam bit WD_EN = (TIMEOUT != 0);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             grant0, grant1;
    logic             wd_fire;

    assign grant0 = (state_q == BUS0);
    assign grant1 = (state_q == BUS1);

    // Grant decisions look only at the owner's CYC and registered state, so the
    // other master's request never reaches this master's ack/err combinationally.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? BUS0 : BUS1;
                else if (m0_cyc_i)        state_d = BUS0;
                else if (m1_cyc_i)        state_d = BUS1;
            end
            BUS0: if (!m0_cyc_i) state_d = m1_cyc_i ? BUS1 : IDLE;
            BUS1: if (!m1_cyc_i) state_d = m0_cyc_i ? BUS0 : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == BUS0 && state_q != BUS0) last_d = 1'b0;
        if (state_d == BUS1 && state_q != BUS1) last_d = 1'b1;
    end

    always_comb begin
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        if (grant0) begin
            s_addr_o = m0_addr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_cyc_i & m0_stb_i;
            s_we_o   = m0_we_i;
        end else if (grant1) begin
            s_addr_o = m1_addr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_cyc_i & m1_stb_i;
            s_we_o   = m1_we_i;
        end
    end

    // A real ack in the fire cycle suppresses the watchdog error.
    assign wd_fire = WD_EN && (wdog_q == CNT_W'(TIMEOUT)) && s_stb_o && !s_ack_i && !s_err_i;

    always_comb begin
        wdog_d = wdog_q + CNT_W'(1);
        if (!WD_EN || state_d != state_q || !s_stb_o || s_ack_i || s_err_i || wd_fire)
            wdog_d = '0;
    end

    // NOTE: state registers use non-blocking assignments and the async reset wins immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = grant0 & s_ack_i;
    assign m1_ack_o = grant1 & s_ack_i;
    assign m0_err_o = grant0 & (s_err_i | wd_fire);
    assign m1_err_o = grant1 & (s_err_i | wd_fire);

endmodule
